// File: rtl/mux_arb_n_to_1_if.sv
// Channel-side and sink-side bundle of the N-to-1 registered mux.
// The slave modport is the mux itself; the master modport is the producers plus the sink.
interface mux_arb_n_to_1_if #(
   parameter int WIDTH  = 4,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = 2
);
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH-1:0]       in_ready;
   logic [WIDTH-1:0]        Y;
   logic                    out_valid;
   logic                    out_ready;
   logic [SEL_W-1:0]        grant;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, Y, out_valid, grant
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, Y, out_valid, grant
   );
endinterface

// File: rtl/mux_arb_n_to_1.sv
// Registered N-to-1 mux with direct-select or round-robin pick; 1 cycle input-to-output latency.
// Backpressure: when the output word is held (out_ready=0), every in_ready is 0.
module mux_arb_n_to_1 #(
   parameter int WIDTH  = 4,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode,
   input  logic [SEL_W-1:0] S,
   mux_arb_n_to_1_if.slave  bus
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [SEL_W-1:0] grant_q, grant_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;

   logic              load_en;
   logic              pick;
   logic              xfer;
   logic [SEL_W-1:0]  sel;
   logic [SEL_W:0]    idx;
   logic              idx_vld;
   logic [NUM_CH-1:0] in_ready;

   assign load_en = (state_q == EMPTY) || bus.out_ready;
   assign xfer    = load_en && pick;

   // Round-robin walks offsets from high to low so the nearest valid channel after ptr wins.
   always_comb begin
      pick    = 1'b0;
      sel     = '0;
      idx     = '0;
      idx_vld = 1'b0;
      if (!mode) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (S == SEL_W'(k) && bus.in_valid[k]) begin
               pick = 1'b1;
               sel  = SEL_W'(k);
            end
         end
      end else begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = {1'b0, ptr_q} + (SEL_W+1)'(i);
            if (idx >= (SEL_W+1)'(NUM_CH)) begin
               idx = idx - (SEL_W+1)'(NUM_CH);
            end
            idx_vld = 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
               if (idx == (SEL_W+1)'(k)) begin
                  idx_vld = bus.in_valid[k];
               end
            end
            if (idx_vld) begin
               pick = 1'b1;
               sel  = idx[SEL_W-1:0];
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (rst_n && xfer && sel == SEL_W'(k)) begin
            in_ready[k] = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         y_q     <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      if (xfer) begin
         state_d = FULL;
      end else if (load_en) begin
         state_d = EMPTY;
      end
   end

   // Datapath next values; ptr only advances on round-robin transfers.
   always_comb begin
      y_d     = y_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      if (xfer) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (sel == SEL_W'(k)) begin
               y_d = bus.in_data[k*WIDTH +: WIDTH];
            end
         end
         grant_d = sel;
         if (mode) begin
            ptr_d = (sel == SEL_W'(NUM_CH - 1)) ? '0 : sel + SEL_W'(1);
         end
      end
   end

   // Outputs
   always_comb begin
      bus.out_valid = (state_q == FULL);
      bus.Y         = y_q;
      bus.grant     = grant_q;
      bus.in_ready  = in_ready;
   end

endmodule

// File: tb/tb_mux_arb_n_to_1.sv
// Directed bench for mux_arb_n_to_1: a 4-channel instance and a 3-channel instance
// for the out-of-range select and non-power-of-two wrap cases.
module tb_mux_arb_n_to_1;
   logic       clk;
   logic       rst_n;
   logic       mode, mode3;
   logic [1:0] S, S3;
   int         total;
   int         bad;
   logic [3:0] exp_d [4];

   mux_arb_n_to_1_if #(.WIDTH(4), .NUM_CH(4), .SEL_W(2)) bus4 ();
   mux_arb_n_to_1_if #(.WIDTH(4), .NUM_CH(3), .SEL_W(2)) bus3 ();

   mux_arb_n_to_1 #(.WIDTH(4), .NUM_CH(4), .SEL_W(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .S(S), .bus(bus4)
   );

   mux_arb_n_to_1 #(.WIDTH(4), .NUM_CH(3), .SEL_W(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .mode(mode3), .S(S3), .bus(bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mode = 1'b1; S = 2'd0;
      bus4.in_data = 16'hC951; bus4.in_valid = 4'hF; bus4.out_ready = 1'b1;
      mode3 = 1'b0; S3 = 2'd0;
      bus3.in_data = 12'h73A; bus3.in_valid = 3'b000; bus3.out_ready = 1'b1;
      #12;
      total++; if (bus4.Y !== 4'h0) begin bad++; $display("FAIL rst_y got=%h want=0", bus4.Y); end
      total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL rst_ov got=%b want=0", bus4.out_valid); end
      total++; if (bus4.grant !== 2'd0) begin bad++; $display("FAIL rst_grant got=%0d want=0", bus4.grant); end
      total++; if (bus4.in_ready !== 4'b0000) begin bad++; $display("FAIL rst_in_ready got=%b want=0000", bus4.in_ready); end
      step();
      rst_n = 1'b1;
      bus4.in_valid = 4'b1010;
      bus4.out_ready = 1'b0;
      step();
      total++; if (bus4.grant !== 2'd1 || bus4.Y !== 4'h5 || bus4.out_valid !== 1'b1)
         begin bad++; $display("FAIL rst_pre_load got g=%0d y=%h ov=%b want g=1 y=5 ov=1", bus4.grant, bus4.Y, bus4.out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (bus4.Y !== 4'h0 || bus4.out_valid !== 1'b0 || bus4.grant !== 2'd0)
         begin bad++; $display("FAIL rst_async got y=%h ov=%b g=%0d want 0/0/0", bus4.Y, bus4.out_valid, bus4.grant); end
      total++; if (bus4.in_ready !== 4'b0000) begin bad++; $display("FAIL rst_async_rdy got=%b want=0000", bus4.in_ready); end
      step();
      rst_n = 1'b1;
      bus4.out_ready = 1'b1;
      step();
      total++; if (bus4.grant !== 2'd1 || bus4.Y !== 4'h5)
         begin bad++; $display("FAIL rst_first_rr got g=%0d y=%h want g=1 y=5", bus4.grant, bus4.Y); end
      bus4.in_valid = 4'b0000;
   endtask

   task automatic test_direct();
      mode = 1'b0;
      bus4.in_valid = 4'hF;
      bus4.out_ready = 1'b1;
      for (int s = 0; s < 4; s++) begin
         S = 2'(s);
         #1;
         total++; if (bus4.in_ready !== (4'b0001 << s))
            begin bad++; $display("FAIL direct_rdy s=%0d got=%b want=%b", s, bus4.in_ready, 4'b0001 << s); end
         step();
         total++; if (bus4.Y !== exp_d[s] || bus4.grant !== 2'(s) || bus4.out_valid !== 1'b1)
            begin bad++; $display("FAIL direct_out s=%0d got y=%h g=%0d ov=%b want y=%h g=%0d ov=1", s, bus4.Y, bus4.grant, bus4.out_valid, exp_d[s], s); end
      end
      bus4.in_valid = 4'b0000;
      step();
      total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL direct_drain got ov=%b want=0", bus4.out_valid); end
   endtask

   task automatic test_rr_fair();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      mode = 1'b1;
      bus4.in_valid = 4'hF;
      bus4.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         total++; if (bus4.grant !== 2'(i % 4) || bus4.Y !== exp_d[i % 4] || bus4.out_valid !== 1'b1)
            begin bad++; $display("FAIL rr_fair i=%0d got g=%0d y=%h ov=%b want g=%0d y=%h ov=1", i, bus4.grant, bus4.Y, bus4.out_valid, i % 4, exp_d[i % 4]); end
      end
      bus4.in_valid = 4'b0000;
   endtask

   task automatic test_wrap_sparse();
      mode = 1'b1;
      bus4.in_valid = 4'b0100;
      step();
      total++; if (bus4.grant !== 2'd2 || bus4.Y !== 4'h9) begin bad++; $display("FAIL wrap_g2 got g=%0d y=%h want g=2 y=9", bus4.grant, bus4.Y); end
      bus4.in_valid = 4'b0010;
      step();
      total++; if (bus4.grant !== 2'd1 || bus4.Y !== 4'h5) begin bad++; $display("FAIL wrap_g1 got g=%0d y=%h want g=1 y=5", bus4.grant, bus4.Y); end
      bus4.in_valid = 4'b1001;
      step();
      total++; if (bus4.grant !== 2'd3 || bus4.Y !== 4'hC) begin bad++; $display("FAIL sparse_g3 got g=%0d y=%h want g=3 y=c", bus4.grant, bus4.Y); end
      step();
      total++; if (bus4.grant !== 2'd0 || bus4.Y !== 4'h1) begin bad++; $display("FAIL sparse_g0 got g=%0d y=%h want g=0 y=1", bus4.grant, bus4.Y); end
      bus4.in_valid = 4'b0000;
      step();
      total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL sparse_drain got ov=%b want=0", bus4.out_valid); end
   endtask

   task automatic test_backpressure();
      mode = 1'b0;
      S = 2'd1;
      bus4.in_valid = 4'b0010;
      bus4.out_ready = 1'b1;
      step();
      total++; if (bus4.Y !== 4'h5 || bus4.out_valid !== 1'b1) begin bad++; $display("FAIL bp_fill got y=%h ov=%b want y=5 ov=1", bus4.Y, bus4.out_valid); end
      bus4.out_ready = 1'b0;
      bus4.in_valid = 4'b0100;
      S = 2'd2;
      #1;
      total++; if (bus4.in_ready !== 4'b0000) begin bad++; $display("FAIL bp_rdy0 got=%b want=0000", bus4.in_ready); end
      for (int c = 0; c < 3; c++) begin
         step();
         total++; if (bus4.Y !== 4'h5 || bus4.out_valid !== 1'b1 || bus4.grant !== 2'd1 || bus4.in_ready !== 4'b0000)
            begin bad++; $display("FAIL bp_hold c=%0d got y=%h ov=%b g=%0d rdy=%b want y=5 ov=1 g=1 rdy=0000", c, bus4.Y, bus4.out_valid, bus4.grant, bus4.in_ready); end
      end
      bus4.out_ready = 1'b1;
      #1;
      total++; if (bus4.in_ready !== 4'b0100) begin bad++; $display("FAIL bp_release_rdy got=%b want=0100", bus4.in_ready); end
      step();
      total++; if (bus4.Y !== 4'h9 || bus4.grant !== 2'd2 || bus4.out_valid !== 1'b1)
         begin bad++; $display("FAIL bp_release got y=%h g=%0d ov=%b want y=9 g=2 ov=1", bus4.Y, bus4.grant, bus4.out_valid); end
   endtask

   task automatic test_edge_sel();
      mode = 1'b0;
      S = 2'd2;
      bus4.in_valid = 4'b1011;
      bus4.out_ready = 1'b1;
      #1;
      total++; if (bus4.in_ready !== 4'b0000) begin bad++; $display("FAIL edge_invalid_rdy got=%b want=0000", bus4.in_ready); end
      step();
      total++; if (bus4.out_valid !== 1'b0 || bus4.Y !== 4'h9 || bus4.grant !== 2'd2)
         begin bad++; $display("FAIL edge_invalid got ov=%b y=%h g=%0d want ov=0 y=9 g=2", bus4.out_valid, bus4.Y, bus4.grant); end
      bus4.in_valid = 4'b0000;

      mode3 = 1'b0;
      S3 = 2'd1;
      bus3.in_valid = 3'b111;
      bus3.out_ready = 1'b1;
      step();
      total++; if (bus3.Y !== 4'h3 || bus3.grant !== 2'd1 || bus3.out_valid !== 1'b1)
         begin bad++; $display("FAIL edge3_load got y=%h g=%0d ov=%b want y=3 g=1 ov=1", bus3.Y, bus3.grant, bus3.out_valid); end
      S3 = 2'd3;
      #1;
      total++; if (bus3.in_ready !== 3'b000) begin bad++; $display("FAIL edge3_oor_rdy got=%b want=000", bus3.in_ready); end
      step();
      total++; if (bus3.Y !== 4'h3 || bus3.out_valid !== 1'b0 || bus3.grant !== 2'd1)
         begin bad++; $display("FAIL edge3_oor got y=%h ov=%b g=%0d want y=3 ov=0 g=1", bus3.Y, bus3.out_valid, bus3.grant); end

      mode3 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (bus3.grant !== 2'(i % 3))
            begin bad++; $display("FAIL edge3_rr_wrap i=%0d got g=%0d want g=%0d", i, bus3.grant, i % 3); end
      end
      bus3.in_valid = 3'b000;
   endtask

   initial begin
      total = 0;
      bad = 0;
      exp_d[0] = 4'h1; exp_d[1] = 4'h5; exp_d[2] = 4'h9; exp_d[3] = 4'hC;
      test_reset();
      test_direct();
      test_rr_fair();
      test_wrap_sparse();
      test_backpressure();
      test_edge_sel();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
